// File: rtl/ripple_divider.sv
// Unsigned multi-cycle restoring divider: one quotient bit per clock, MSB first,
// with an explicit ripple-borrow subtractor and a ready/valid/ack handshake.
module ripple_divider #(
  parameter signed [31:0] N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ack,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  // Dividend shifts out MSB first while quotient bits shift in at the LSB.
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    trial_s;
  logic [N:0]    sub_s;
  logic          borrow_s;
  logic [N-1:0]  prem_step_s;
  logic [N-1:0]  dvd_step_s;
  logic          last_s;

  // Returns {borrow_out, difference[N-1:0]} of x - y over an N+1-bit ripple chain.
  function automatic logic [N:0] sub_borrow(input logic [N:0] x, input logic [N:0] y);
    logic [N:0] diff;
    logic       br;
    br = 1'b0;
    for (int i = 0; i <= N; i++) begin
      diff[i] = x[i] ^ y[i] ^ br;
      br      = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, diff[N-1:0]};
  endfunction

  // One restoring step: trial subtract, keep the difference only when no borrow.
  always_comb begin
    trial_s     = {prem_q, dvd_q[N-1]};
    sub_s       = sub_borrow(trial_s, {1'b0, dvs_q});
    borrow_s    = sub_s[N];
    if (borrow_s) begin
      prem_step_s = trial_s[N-1:0];
    end else begin
      prem_step_s = sub_s[N-1:0];
    end
    dvd_step_s  = {dvd_q[N-2:0], ~borrow_s};
    last_s      = (cnt_q == CW'(N - 1));
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= {N{1'b0}};
      dvs_q   <= {N{1'b0}};
      prem_q  <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
      quo_q   <= {N{1'b0}};
      rem_q   <= {N{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b != {N{1'b0}}) begin
            state_d = CALC;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates; results are committed to quo/rem only on entry to DONE.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = a;
          dvs_d  = b;
          prem_d = {N{1'b0}};
          cnt_d  = {CW{1'b0}};
          if (b == {N{1'b0}}) begin
            quo_d = {N{1'b1}};
            rem_d = a;
            dbz_d = 1'b1;
          end else begin
            quo_d = {N{1'b0}};
            rem_d = {N{1'b0}};
            dbz_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      CALC: begin
        dvd_d  = dvd_step_s;
        prem_d = prem_step_s;
        cnt_d  = cnt_q + CW'(1);
        if (last_s) begin
          quo_d = dvd_step_s;
          rem_d = prem_step_s;
        end else begin
          quo_d = quo_q;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from registered state and result registers.
  always_comb begin
    ready       = (state_q == IDLE);
    valid       = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_ripple_divider.sv
// Scoreboard bench for ripple_divider (N=4): expectations are queued at start
// acceptance and checked when valid rises.
module tb_ripple_divider;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         ready;
  logic         valid;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int   tests_run = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ripple_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ack(ack),
    .ready(ready), .valid(valid), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    if (y == 0) begin
      e.q = {N{1'b1}}; e.r = x; e.z = 1'b1;
    end else begin
      e.q = x / y; e.r = x % y; e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1; a = x; b = y;
    sb.push_back(model(x, y));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 4'd13; b = 4'd3; ack = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({ready, valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%0d r=%0d z=%b, want rdy=1 vld=0 q=0 r=0 z=0",
               ready, valid, quotient, remainder, div_by_zero);
    end
    start = 1'b0; ack = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc; exp_t e;
    issue(4'd13, 4'd3);
    wait_valid(cyc);
    pop_exp(e);
    tests_run++;
    if (cyc !== 5) begin
      fails++; $display("FAIL basic_latency: got %0d cycles, want 5", cyc);
    end
    tests_run++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || e.q !== 4'd4 || e.r !== 4'd1) begin
      fails++;
      $display("FAIL basic_13_3: got q=%0d r=%0d z=%b, want q=4 r=1 z=0", quotient, remainder, div_by_zero);
    end
    do_ack();
  endtask

  task automatic test_patterns();
    int cyc; exp_t e;
    logic [N-1:0] xs [2];
    logic [N-1:0] ys [2];
    xs[0] = 4'd15; ys[0] = 4'd1;
    xs[1] = 4'd3;  ys[1] = 4'd9;
    for (int i = 0; i < 2; i++) begin
      issue(xs[i], ys[i]);
      wait_valid(cyc);
      pop_exp(e);
      tests_run++;
      if (valid !== 1'b1 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
        fails++;
        $display("FAIL pattern_%0d_%0d: got vld=%b q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                 xs[i], ys[i], valid, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
      do_ack();
    end
  endtask

  task automatic test_div_zero();
    int cyc; exp_t e;
    issue(4'd7, 4'd0);
    wait_valid(cyc);
    pop_exp(e);
    tests_run++;
    if (cyc !== 1) begin
      fails++; $display("FAIL dbz_latency: got %0d cycles, want 1", cyc);
    end
    tests_run++;
    if ({quotient, remainder, div_by_zero} !== {4'd15, 4'd7, 1'b1}) begin
      fails++;
      $display("FAIL dbz_7_0: got q=%0d r=%0d z=%b, want q=15 r=7 z=1", quotient, remainder, div_by_zero);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int cyc; exp_t e; bit stable;
    issue(4'd11, 4'd2);
    wait_valid(cyc);
    pop_exp(e);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid !== 1'b1 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) stable = 1'b0;
    end
    tests_run++;
    if (!stable) begin
      fails++;
      $display("FAIL hold_no_ack: got vld=%b q=%0d r=%0d z=%b, want vld=1 q=%0d r=%0d z=%b held",
               valid, quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    do_ack();
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      fails++; $display("FAIL ack_to_ready: got rdy=%b vld=%b, want rdy=1 vld=0", ready, valid);
    end
    issue(4'd9, 4'd2);
    wait_valid(cyc);
    pop_exp(e);
    tests_run++;
    if (valid !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1 || {quotient, remainder} !== {e.q, e.r}) begin
      fails++;
      $display("FAIL b2b_9_2: got vld=%b q=%0d r=%0d, want q=4 r=1", valid, quotient, remainder);
    end
    do_ack();
  endtask

  task automatic test_ignore_start();
    int cyc; exp_t e;
    issue(4'd14, 4'd3);
    start = 1'b1; a = 4'd5; b = 4'd1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    tick();
    start = 1'b1; a = 4'd2; b = 4'd0;
    tick();
    start = 1'b0;
    wait_valid(cyc);
    pop_exp(e);
    tests_run++;
    if (cyc + 3 !== 5 || {quotient, remainder, div_by_zero} !== {4'd4, 4'd2, 1'b0} ||
        {quotient, remainder} !== {e.q, e.r}) begin
      fails++;
      $display("FAIL ignore_start: got cyc=%0d q=%0d r=%0d z=%b, want cyc=2 q=4 r=2 z=0",
               cyc, quotient, remainder, div_by_zero);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(4'd13, 4'd3);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid_calc: got rdy=%b vld=%b q=%0d r=%0d, want rdy=1 vld=0 q=0 r=0",
               ready, valid, quotient, remainder);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid !== 1'b0 || ready !== 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      fails++; $display("FAIL reset_abandon: got valid or not-ready after reset, want idle with no valid");
    end
  endtask

  task automatic test_sweep();
    int cyc; exp_t e;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        issue(x[N-1:0], y[N-1:0]);
        wait_valid(cyc);
        pop_exp(e);
        tests_run++;
        if (valid !== 1'b1 || cyc !== ((y == 0) ? 1 : 5) ||
            {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
          fails++;
          $display("FAIL sweep_%0d_%0d: got vld=%b cyc=%0d q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                   x, y, valid, cyc, quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        do_ack();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ripple_divider.md
RIPPLE_DIVIDER -- requirements
Module: ripple_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, declared signed [31:0], giving the operand and result width in bits (legal range N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset; one clock, reset synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; accepted only in a cycle where ready=1.
REQ-005 The block SHALL have port a, input, N bits: unsigned dividend, sampled with an accepted start.
REQ-006 The block SHALL have port b, input, N bits: unsigned divisor, sampled with an accepted start.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer accepts the result; meaningful only while valid=1.
REQ-008 The block SHALL have port ready, output, 1 bit: high exactly in state IDLE.
REQ-009 The block SHALL have port valid, output, 1 bit: high exactly in state DONE.
REQ-010 The block SHALL have port quotient, output, N bits: the result quotient.
REQ-011 The block SHALL have port remainder, output, N bits: the result remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: flags that the latched b was 0.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a and b, clear the partial remainder and the bit counter, and select the next state by b.
REQ-015 From IDLE with start=1, the next state SHALL be CALC if b!=0, or DONE if b=0.
REQ-016 In CALC, the block SHALL resolve one quotient bit per cycle, MSB first, by restoring division.
REQ-017 Each CALC cycle SHALL form t = {partial remainder, next dividend bit} as an N+1-bit value and compute t - {0,b} through an N+1-bit borrow chain.
REQ-018 In a CALC step, if there is no borrow, the partial remainder SHALL take the difference and the quotient bit SHALL be 1; otherwise t is kept and the quotient bit SHALL be 0.
REQ-019 CALC SHALL last exactly N cycles, tracked by a counter of width $clog2(N+1), after which the state SHALL be DONE.
REQ-020 Latency SHALL be: start accepted at edge 0, valid=1 after edge N+1 (b!=0) or after edge 1 (b=0).
REQ-021 On divide by zero, the block SHALL produce quotient all ones, remainder = a and div_by_zero=1; otherwise div_by_zero=0.
REQ-022 In DONE, quotient, remainder and div_by_zero SHALL hold stable until ack=1.
REQ-023 On ack=1 in DONE, the block SHALL go to IDLE at the next edge, with ready=1 from the following cycle.
REQ-024 ack SHALL be ignored outside DONE.
REQ-025 start SHALL be ignored while ready=0; no re-latching and no restart.
REQ-026 Outputs quotient and remainder SHALL be registered; their values outside DONE are don't-care for consumers but SHALL be deterministic.
REQ-027 Back-to-back operation: start asserted in the first cycle IDLE is re-entered SHALL be accepted.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL enter IDLE, with ready=1, valid=0, quotient=0, remainder=0, div_by_zero=0, and counter and partial remainder cleared.
REQ-029 Reset SHALL take priority over start and ack.
REQ-030 Reset asserted mid-CALC or in DONE SHALL abandon the operation; no valid is produced for it.

Verification (N=4)
REQ-031 The bench SHALL check: a=13, b=3, start pulse -> valid high 5 cycles after acceptance, quotient=4, remainder=1, div_by_zero=0.
REQ-032 The bench SHALL check: a=15, b=1 -> quotient=15, remainder=0; and a=3, b=9 -> quotient=0, remainder=3.
REQ-033 The bench SHALL check: a=7, b=0 -> valid after 1 cycle, quotient=15, remainder=7, div_by_zero=1.
REQ-034 The bench SHALL check: ack held low 10 cycles in DONE -> outputs stable; then ack=1 -> ready=1 next cycle; start with a=9, b=2 that cycle -> quotient=4, remainder=1.
REQ-035 The bench SHALL check: start toggled with new operands during CALC -> ignored, original result delivered; rst_n=0 at the 2nd CALC cycle -> IDLE, valid never asserted.
REQ-036 The bench SHALL check: exhaustive sweep of all 256 (a,b) pairs against the reference model a/b, a%b, with the divide-by-zero rule.
